// File: rtl/rgu_push_arbiter.sv
// Merges the single-cycle push streams of NUM_RGU ray generation units onto
// one downstream ray FIFO write port. Each lane has a small circular buffer
// because the RGUs cannot be stalled. A round-robin scheduler drains the
// buffers one word per cycle while the downstream FIFO is not full.
module rgu_push_arbiter #(
  parameter int NUM_RGU = 4,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 4,
  parameter int SRC_W   = 2
) (
  input  logic                      iClock,
  input  logic                      iReset,
  input  logic [NUM_RGU-1:0]        iPush,
  input  logic [NUM_RGU*DATA_W-1:0] iData,
  input  logic                      iDownFull,
  input  logic                      iClearOverflow,
  output logic                      oPush,
  output logic [DATA_W-1:0]         oData,
  output logic [SRC_W-1:0]          oSource,
  output logic [NUM_RGU-1:0]        oOverflow,
  output logic                      oPending
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  // Lane buffer storage and bookkeeping
  logic [DATA_W-1:0] laneMem [NUM_RGU][DEPTH];
  logic [PTR_W-1:0]  wrPtr   [NUM_RGU];
  logic [PTR_W-1:0]  rdPtr   [NUM_RGU];
  logic [CNT_W-1:0]  count   [NUM_RGU];
  logic [CNT_W-1:0]  countNext [NUM_RGU];
  logic [SRC_W-1:0]  rr;

  logic [NUM_RGU-1:0] nonEmpty;
  logic [NUM_RGU-1:0] laneFull;
  logic [NUM_RGU-1:0] popLane;
  logic [NUM_RGU-1:0] pushAcc;
  logic [NUM_RGU-1:0] pushDrop;
  logic               anyNext;

  // Grant stage (combinational, feeds the output register)
  logic               vld_p0;
  logic [SRC_W-1:0]   grantLane_p0;
  logic [DATA_W-1:0]  headWord_p0;
  logic [SRC_W:0]     pick_p0;

  // Round-robin search: first requesting lane after 'last', wrapping modulo
  // NUM_RGU. Iterating from the farthest candidate down lets the nearest one
  // overwrite the result, so no early-exit flag is needed. MSB = found.
  function automatic logic [SRC_W:0] pickLane(
    input logic [NUM_RGU-1:0] req,
    input logic [SRC_W-1:0]   last
  );
    logic [SRC_W:0]   res;
    logic [SRC_W-1:0] idx;
    res = '0;
    for (int k = NUM_RGU; k >= 1; k--) begin
      idx = SRC_W'((int'(last) + k) % NUM_RGU);
      if (req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  // Lane occupancy flags derived from the registered counts
  always_comb begin
    nonEmpty = '0;
    laneFull = '0;
    for (int i = 0; i < NUM_RGU; i++) begin
      nonEmpty[i] = (count[i] != '0);
      laneFull[i] = (count[i] == CNT_FULL);
    end
  end

  // Grant selection; a full downstream FIFO suppresses any new grant
  always_comb begin
    pick_p0      = pickLane(nonEmpty, rr);
    vld_p0       = pick_p0[SRC_W] && !iDownFull;
    grantLane_p0 = pick_p0[SRC_W-1:0];
    headWord_p0  = laneMem[grantLane_p0][rdPtr[grantLane_p0]];
  end

  // Per-lane push acceptance, drop detection and next-count computation.
  // A full lane that is popped this cycle frees the slot the push needs.
  always_comb begin
    popLane  = '0;
    pushAcc  = '0;
    pushDrop = '0;
    anyNext  = 1'b0;
    for (int i = 0; i < NUM_RGU; i++) begin
      countNext[i] = count[i];
      popLane[i]   = vld_p0 && (grantLane_p0 == SRC_W'(i));
      pushAcc[i]   = iPush[i] && (!laneFull[i] || popLane[i]);
      pushDrop[i]  = iPush[i] && laneFull[i] && !popLane[i];
      if (pushAcc[i] && !popLane[i]) begin
        countNext[i] = count[i] + CNT_W'(1);
      end else if (!pushAcc[i] && popLane[i]) begin
        countNext[i] = count[i] - CNT_W'(1);
      end
      anyNext = anyNext || (countNext[i] != '0);
    end
  end

  // Buffer storage writes; storage is never reset, validity lives in count
  always_ff @(posedge iClock) begin
    for (int i = 0; i < NUM_RGU; i++) begin
      if (pushAcc[i]) begin
        laneMem[i][wrPtr[i]] <= iData[i*DATA_W +: DATA_W];
      end
    end
  end

  // Pointer/count/round-robin state and the registered output stage
  always_ff @(posedge iClock) begin
    if (iReset) begin
      for (int i = 0; i < NUM_RGU; i++) begin
        wrPtr[i] <= '0;
        rdPtr[i] <= '0;
        count[i] <= '0;
      end
      rr        <= SRC_W'(NUM_RGU - 1);
      oPush     <= 1'b0;
      oData     <= '0;
      oSource   <= '0;
      oOverflow <= '0;
      oPending  <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_RGU; i++) begin
        if (pushAcc[i]) wrPtr[i] <= wrPtr[i] + PTR_W'(1);
        if (popLane[i]) rdPtr[i] <= rdPtr[i] + PTR_W'(1);
        count[i] <= countNext[i];
      end
      // ---- stage p0 -> p1: grant becomes the downstream write ----
      oPush <= vld_p0;
      if (vld_p0) begin
        rr      <= grantLane_p0;
        oData   <= headWord_p0;
        oSource <= grantLane_p0;
      end
      // A drop in the same cycle as a clear pulse must stay visible
      oOverflow <= (oOverflow & ~{NUM_RGU{iClearOverflow}}) | pushDrop;
      oPending  <= anyNext;
    end
  end

endmodule

// File: tb/tb_rgu_push_arbiter.sv
// Self-checking bench for rgu_push_arbiter: a scoreboard queue of expected
// downstream writes, a table of single-lane latency vectors and hand-written
// sequences for round-robin, overflow and reset corner cases.
module tb_rgu_push_arbiter;

  localparam int NUM_RGU = 4;
  localparam int DATA_W  = 32;
  localparam int DEPTH   = 4;
  localparam int SRC_W   = 2;

  logic                      iClock = 1'b0;
  logic                      iReset = 1'b1;
  logic [NUM_RGU-1:0]        iPush;
  logic [NUM_RGU*DATA_W-1:0] iData;
  logic                      iDownFull;
  logic                      iClearOverflow;
  logic                      oPush;
  logic [DATA_W-1:0]         oData;
  logic [SRC_W-1:0]          oSource;
  logic [NUM_RGU-1:0]        oOverflow;
  logic                      oPending;

  rgu_push_arbiter #(
    .NUM_RGU(NUM_RGU), .DATA_W(DATA_W), .DEPTH(DEPTH), .SRC_W(SRC_W)
  ) dut (
    .iClock(iClock), .iReset(iReset), .iPush(iPush), .iData(iData),
    .iDownFull(iDownFull), .iClearOverflow(iClearOverflow),
    .oPush(oPush), .oData(oData), .oSource(oSource),
    .oOverflow(oOverflow), .oPending(oPending)
  );

  always #5 iClock = ~iClock;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [SRC_W-1:0]  src;
  } exp_t;

  typedef struct {
    int                lane;
    logic [DATA_W-1:0] data;
    logic [SRC_W-1:0]  expSrc;
    logic [DATA_W-1:0] expData;
  } vec_t;

  exp_t expQ[$];
  vec_t vecs[4];
  int   nChecks = 0;
  int   nErrors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mkExp(input logic [DATA_W-1:0] d, input int s);
    exp_t e;
    e.data = d;
    e.src  = SRC_W'(s);
    return e;
  endfunction

  task automatic tick();
    @(posedge iClock);
    #1;
  endtask

  task automatic setData(input int lane, input logic [DATA_W-1:0] val);
    iData[lane*DATA_W +: DATA_W] = val;
  endtask

  task automatic pushOne(input int lane, input logic [DATA_W-1:0] val);
    iPush       = '0;
    iPush[lane] = 1'b1;
    setData(lane, val);
  endtask

  task automatic resetDut();
    iPush  = '0;
    iReset = 1'b1;
    tick();
    iReset = 1'b0;
    expQ.delete();
  endtask

  // Wait, with a cycle budget, for every expected word to come out
  task automatic drain(input string name);
    int budget;
    budget = 0;
    while (expQ.size() != 0 && budget < 64) begin
      tick();
      budget++;
    end
    repeat (3) tick();
    check(name, 64'(expQ.size()), 64'd0);
  endtask

  // Scoreboard: every downstream write must match the oldest expected word
  always @(negedge iClock) begin
    exp_t e;
    if (oPush === 1'b1) begin
      if (expQ.size() == 0) begin
        nChecks++;
        nErrors++;
        $display("FAIL unexpected_push: got src %0d data 0x%0h, expected no write", oSource, oData);
      end else begin
        e = expQ.pop_front();
        check("sb_data", 64'(oData), 64'(e.data));
        check("sb_src", 64'(oSource), 64'(e.src));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int pulses;
    int seen;
    iPush          = '0;
    iData          = '0;
    iDownFull      = 1'b0;
    iClearOverflow = 1'b0;

    vecs[0] = '{lane: 0, data: 32'h0006_0000, expSrc: 2'd0, expData: 32'h0006_0000};
    vecs[1] = '{lane: 1, data: 32'h1234_5678, expSrc: 2'd1, expData: 32'h1234_5678};
    vecs[2] = '{lane: 3, data: 32'hFFFF_FFFF, expSrc: 2'd3, expData: 32'hFFFF_FFFF};
    vecs[3] = '{lane: 2, data: 32'h0000_0000, expSrc: 2'd2, expData: 32'h0000_0000};

    // Reset state
    tick();
    tick();
    check("rst_push", 64'(oPush), 64'd0);
    check("rst_data", 64'(oData), 64'd0);
    check("rst_src", 64'(oSource), 64'd0);
    check("rst_ovf", 64'(oOverflow), 64'd0);
    check("rst_pend", 64'(oPending), 64'd0);
    iReset = 1'b0;

    // Single-lane latency table: push at edge k, write visible after edge k+1
    for (int v = 0; v < 4; v++) begin
      pushOne(vecs[v].lane, vecs[v].data);
      expQ.push_back(mkExp(vecs[v].expData, int'(vecs[v].expSrc)));
      tick();
      iPush = '0;
      check("lat_t1_push", 64'(oPush), 64'd0);
      check("lat_t1_pend", 64'(oPending), 64'd1);
      tick();
      check("lat_t2_push", 64'(oPush), 64'd1);
      check("lat_t2_data", 64'(oData), 64'(vecs[v].expData));
      check("lat_t2_src", 64'(oSource), 64'(vecs[v].expSrc));
      check("lat_t2_pend", 64'(oPending), 64'd0);
      tick();
      check("lat_t3_push", 64'(oPush), 64'd0);
      check("lat_hold_data", 64'(oData), 64'(vecs[v].expData));
    end
    drain("drain_table");

    // All four lanes push together: lanes served 0,1,2,3 back to back
    resetDut();
    iPush = 4'hF;
    for (int i = 0; i < NUM_RGU; i++) begin
      setData(i, DATA_W'(32'hA0 + i));
      expQ.push_back(mkExp(DATA_W'(32'hA0 + i), i));
    end
    tick();
    iPush  = '0;
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (oPush === 1'b1) pulses++;
    end
    check("all4_pulses", 64'(pulses), 64'd4);
    drain("drain_all4");

    // Lanes 1 and 3 push every cycle for 8 cycles: strict alternation 1,3,...
    // Lane 3 receives its 8th word while full and not granted, so it drops.
    resetDut();
    for (int k = 0; k < 7; k++) begin
      expQ.push_back(mkExp(DATA_W'(32'h100 + k), 1));
      expQ.push_back(mkExp(DATA_W'(32'h300 + k), 3));
    end
    expQ.push_back(mkExp(DATA_W'(32'h107), 1));
    for (int k = 0; k < 8; k++) begin
      iPush = 4'b1010;
      setData(1, DATA_W'(32'h100 + k));
      setData(3, DATA_W'(32'h300 + k));
      tick();
    end
    iPush = '0;
    check("rr_ovf", 64'(oOverflow), 64'(4'b1000));
    drain("drain_rr");

    // Downstream full: lane 2 overflows, nothing is written until release
    resetDut();
    iDownFull = 1'b1;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      pushOne(2, DATA_W'(32'h200 + k));
      if (k < DEPTH) expQ.push_back(mkExp(DATA_W'(32'h200 + k), 2));
      tick();
      if (oPush !== 1'b0) seen++;
    end
    iPush = '0;
    tick();
    if (oPush !== 1'b0) seen++;
    check("full_no_push", 64'(seen), 64'd0);
    check("full_ovf", 64'(oOverflow), 64'(4'b0100));
    check("full_pend", 64'(oPending), 64'd1);
    check("full_queued", 64'(expQ.size()), 64'd4);
    iDownFull = 1'b0;
    drain("drain_full");
    check("ovf_sticky", 64'(oOverflow), 64'(4'b0100));
    check("empty_pend", 64'(oPending), 64'd0);
    iClearOverflow = 1'b1;
    tick();
    iClearOverflow = 1'b0;
    check("ovf_cleared", 64'(oOverflow), 64'd0);

    // A drop coinciding with a clear pulse leaves the flag set
    resetDut();
    iDownFull = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      pushOne(1, DATA_W'(32'h500 + k));
      expQ.push_back(mkExp(DATA_W'(32'h500 + k), 1));
      tick();
    end
    pushOne(1, 32'h0000_05FF);
    iClearOverflow = 1'b1;
    tick();
    iPush          = '0;
    iClearOverflow = 1'b0;
    check("set_over_clear", 64'(oOverflow), 64'(4'b0010));
    iDownFull = 1'b0;
    drain("drain_soc");

    // Full lane 0 pushed in the same cycle it is granted: push accepted
    resetDut();
    iDownFull = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      pushOne(0, DATA_W'(32'h400 + k));
      expQ.push_back(mkExp(DATA_W'(32'h400 + k), 0));
      tick();
    end
    pushOne(0, 32'h0000_0404);
    expQ.push_back(mkExp(32'h0000_0404, 0));
    iDownFull = 1'b0;
    tick();
    check("popfull_ovf", 64'(oOverflow), 64'd0);
    // Count must still be DEPTH, so a push with no grant now drops
    iDownFull = 1'b1;
    pushOne(0, 32'h0000_04AA);
    tick();
    iPush = '0;
    check("popfull_count", 64'(oOverflow), 64'(4'b0001));
    iClearOverflow = 1'b1;
    tick();
    iClearOverflow = 1'b0;
    iDownFull      = 1'b0;
    drain("drain_popfull");

    // Reset while three lanes hold data (and overflow flags are set)
    resetDut();
    iDownFull = 1'b1;
    for (int k = 0; k < 5; k++) begin
      iPush = 4'b1011;
      setData(0, DATA_W'(32'h600 + k));
      setData(1, DATA_W'(32'h610 + k));
      setData(3, DATA_W'(32'h630 + k));
      tick();
    end
    iPush = '0;
    check("pre_rst_ovf", 64'(oOverflow), 64'(4'b1011));
    iReset    = 1'b1;
    iDownFull = 1'b0;
    tick();
    iReset = 1'b0;
    check("midrst_push", 64'(oPush), 64'd0);
    check("midrst_pend", 64'(oPending), 64'd0);
    check("midrst_ovf", 64'(oOverflow), 64'd0);
    pushOne(2, 32'hC0FF_EE02);
    expQ.push_back(mkExp(32'hC0FF_EE02, 2));
    tick();
    iPush = '0;
    check("postrst_t1_push", 64'(oPush), 64'd0);
    tick();
    check("postrst_t2_push", 64'(oPush), 64'd1);
    check("postrst_t2_src", 64'(oSource), 64'd2);
    check("postrst_t2_data", 64'(oData), 64'(32'hC0FF_EE02));
    drain("drain_postrst");

    repeat (4) tick();
    check("final_queue", 64'(expQ.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
